mult_control: RTL and testbench

Sequencing FSM for the sequential 8x8 multiplier. It is the driving end of the 16-bit accumulator register's control interface. It generates the accumulator's `clk_ena`/`sclr_n` and the datapath's nibble-select and shift-select codes. It steps the four 4x4 partial products into the accumulator and flags completion. It sits between the top-level `start` input and the datapath (4x4 multiplier, nibble muxes, shifter, adder, 16-bit register).

---
 rtl/mult_control.sv | 179 +++++++++++++++++
 tb/tb_mult_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// -----------------------------------------------------------------------------
// mult_control
// Sequencing FSM for the sequential 8x8 multiplier. Drives the 16-bit
// accumulator's load enable / synchronous clear and the datapath's nibble and
// shift selects, stepping the four 4x4 partial products into the accumulator.
//
// Parameters:
//   DONE_CYCLES  cycles 'done' is held in CALC_DONE (legal 1..4)
//
// Ports:
//   clk        rising-edge clock (shared with the accumulator)
//   aclr_n     asynchronous active-low reset
//   start      start request, sampled on clk
//   input_sel  operand nibble select: 00 alo*blo, 01 ahi*blo, 10 alo*bhi, 11 ahi*bhi
//   shift_sel  partial-product shift: 00 <<0, 01 <<4, 10 <<8, 11 unused
//   clk_ena    accumulator load enable
//   sclr_n     accumulator synchronous clear, active-low
//   done       product valid on accumulator output
//   err        start seen while busy (only with MULT_CTRL_ERR_EN, else 0)
//   state_out  encoded state for debug display
//
// Build option:
//   MULT_CTRL_ERR_EN  enables the ERR state and the err output; when undefined
//                     a start during a product is ignored.
// -----------------------------------------------------------------------------
module mult_control #(
  parameter int DONE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       aclr_n,
  input  logic       start,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out
);

  // Encodings are fixed: they are visible on state_out.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LSB       = 3'd1,
    MID       = 3'd2,
    MSB       = 3'd3,
`ifdef MULT_CTRL_ERR_EN
    ERR       = 3'd5,
`endif
    CALC_DONE = 3'd4
  } state_t;

  localparam logic [1:0] DONE_LAST = 2'(DONE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] count, count_nxt;

  logic       ena_moore;
  logic       can_restart;
  logic       restart;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LSB;
          count_nxt = '0;
        end
      end
      LSB: begin
        state_nxt = MID;
        count_nxt = '0;
      end
      MID: begin
        // Two sub-steps share MID: the cross products ahi*blo and alo*bhi.
        if (count == 2'd0) begin
          count_nxt = 2'd1;
        end else begin
          state_nxt = MSB;
          count_nxt = '0;
        end
      end
      MSB: begin
        state_nxt = CALC_DONE;
        count_nxt = '0;
      end
      CALC_DONE: begin
        if (start) begin
          state_nxt = LSB;
          count_nxt = '0;
        end else if (count == DONE_LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + 2'd1;
        end
      end
`ifdef MULT_CTRL_ERR_EN
      ERR: begin
        if (start) begin
          state_nxt = LSB;
          count_nxt = '0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase

`ifdef MULT_CTRL_ERR_EN
    // A start while a product is in flight aborts it into ERR.
    if (start && (state == LSB || state == MID || state == MSB)) begin
      state_nxt = ERR;
      count_nxt = '0;
    end
`endif
  end

  always_comb begin
    input_sel   = '0;
    shift_sel   = '0;
    ena_moore   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    can_restart = 1'b0;
    case (state)
      IDLE: begin
        can_restart = 1'b1;
      end
      LSB: begin
        ena_moore = 1'b1;
      end
      MID: begin
        ena_moore = 1'b1;
        shift_sel = 2'b01;
        input_sel = (count == 2'd0) ? 2'b01 : 2'b10;
      end
      MSB: begin
        ena_moore = 1'b1;
        shift_sel = 2'b10;
        input_sel = 2'b11;
      end
      CALC_DONE: begin
        done        = 1'b1;
        can_restart = 1'b1;
      end
`ifdef MULT_CTRL_ERR_EN
      ERR: begin
        err         = 1'b1;
        can_restart = 1'b1;
      end
`endif
      default: ;
    endcase

    // Mealy clear: a start in a restartable state clears the accumulator on
    // this same edge. Masked during reset so sclr_n reads 1 while aclr_n=0.
    restart = aclr_n & start & can_restart;
    clk_ena = ena_moore | restart;
    sclr_n  = ~restart;
  end

  assign state_out = state;

endmodule

// File: tb/tb_mult_control.sv
// -----------------------------------------------------------------------------
// tb_mult_control
// Bench for mult_control. Two instances (DONE_CYCLES=1 and 3) each drive a
// behavioural accumulator datapath; expected products are queued when a start
// is issued and compared when done rises. Control outputs are compared
// cycle-by-cycle against fixed tables.
// -----------------------------------------------------------------------------
module tb_mult_control;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        start1, start3;
  logic [1:0]  isel1, ssel1, isel3, ssel3;
  logic        ena1, sclr1, done1, err1;
  logic        ena3, sclr3, done3, err3;
  logic [2:0]  st1, st3;
  logic [7:0]  a1, b1, a3, b3;
  logic [15:0] acc1, acc3;
  logic        done1_q = 1'b0;
  logic        done3_q = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] sb1[$];
  logic [15:0] sb3[$];

  always #5 clk = ~clk;

  mult_control #(.DONE_CYCLES(1)) dut1 (
    .clk(clk), .aclr_n(aclr_n), .start(start1),
    .input_sel(isel1), .shift_sel(ssel1), .clk_ena(ena1), .sclr_n(sclr1),
    .done(done1), .err(err1), .state_out(st1)
  );

  mult_control #(.DONE_CYCLES(3)) dut3 (
    .clk(clk), .aclr_n(aclr_n), .start(start3),
    .input_sel(isel3), .shift_sel(ssel3), .clk_ena(ena3), .sclr_n(sclr3),
    .done(done3), .err(err3), .state_out(st3)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Packed control word: {state, input_sel, shift_sel, clk_ena, sclr_n, done, err}
  function automatic logic [15:0] pk(input logic [2:0] st, input logic [1:0] is,
                                     input logic [1:0] ss, input logic en,
                                     input logic sc, input logic dn, input logic er);
    return {5'b0, st, is, ss, en, sc, dn, er};
  endfunction

  // Datapath partial product: nibble muxes, 4x4 multiply, shifter.
  function automatic logic [15:0] pp(input logic [1:0] is, input logic [1:0] ss,
                                     input logic [7:0] a, input logic [7:0] b);
    logic [3:0] an, bn;
    logic [7:0] p;
    an = is[0] ? a[7:4] : a[3:0];
    bn = is[1] ? b[7:4] : b[3:0];
    p  = an * bn;
    case (ss)
      2'b00:   return {8'h00, p};
      2'b01:   return {4'h0, p, 4'h0};
      2'b10:   return {p, 8'h00};
      default: return 16'h0000;
    endcase
  endfunction

  // Accumulators: no reset, clear has priority when enabled.
  always @(posedge clk) begin
    if (ena1) acc1 <= sclr1 ? acc1 + pp(isel1, ssel1, a1, b1) : 16'h0000;
    if (ena3) acc3 <= sclr3 ? acc3 + pp(isel3, ssel3, a3, b3) : 16'h0000;
  end

  // Scoreboard: compare on each rising edge of done.
  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (sb1.size() == 0) check("sb1_unexpected_done", 16'd1, 16'd0);
      else                 check("product1", acc1, sb1.pop_front());
    end
    if (done3 && !done3_q) begin
      if (sb3.size() == 0) check("sb3_unexpected_done", 16'd1, 16'd0);
      else                 check("product3", acc3, sb3.pop_front());
    end
    done1_q = done1;
    done3_q = done3;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t_st  [6] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [1:0] t_is  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
  logic [1:0] t_ss  [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
  logic       t_en  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       t_dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] t3_st [4] = '{3'd4, 3'd4, 3'd4, 3'd0};
  logic       t3_dn [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    aclr_n = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    a1 = '0; b1 = '0; a3 = '0; b3 = '0;
    #2;
    check("reset1", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    check("reset3", pk(st3, isel3, ssel3, ena3, sclr3, done3, err3),
          pk(3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    aclr_n = 1'b1;
    tick;

    // Single product, DONE_CYCLES=1
    a1 = 8'hFF; b1 = 8'hFF;
    start1 = 1'b1;
    sb1.push_back(16'hFE01);
    #1;
    check("start_e0", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    tick;
    start1 = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      check($sformatf("seq1_step%0d", i), pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
            pk(t_st[i], t_is[i], t_ss[i], t_en[i], 1'b1, t_dn[i], 1'b0));
      tick;
    end

    // DONE_CYCLES=3: done held exactly three cycles
    a3 = 8'h12; b3 = 8'h34;
    start3 = 1'b1;
    sb3.push_back(16'h03A8);
    tick;
    start3 = 1'b0;
    repeat (3) tick;
    check("dc3_msb", 16'(st3), 16'd3);
    for (int unsigned i = 0; i < 4; i++) begin
      tick;
      check($sformatf("dc3_hold%0d", i), pk(st3, isel3, ssel3, ena3, sclr3, done3, err3),
            pk(t3_st[i], 2'd0, 2'd0, 1'b0, 1'b1, t3_dn[i], 1'b0));
    end

    // Back-to-back: restart from CALC_DONE
    a1 = 8'h12; b1 = 8'h34;
    start1 = 1'b1;
    sb1.push_back(16'h03A8);
    tick;
    start1 = 1'b0;
    repeat (4) tick;
    check("b2b_first_done", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd4, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    a1 = 8'h0F; b1 = 8'hF0;
    start1 = 1'b1;
    sb1.push_back(16'h0E10);
    #1;
    check("b2b_clear", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    tick;
    start1 = 1'b0;
    check("b2b_lsb", 16'(st1), 16'd1);
    repeat (4) tick;
    check("b2b_second_done", 16'({st1, done1}), 16'({3'd4, 1'b1}));
    tick;
    check("b2b_idle", 16'(st1), 16'd0);

    // Start while busy (in MID)
    a1 = 8'h55; b1 = 8'hAA;
    start1 = 1'b1;
    sb1.push_back(16'h3872);
    tick;
    start1 = 1'b0;
    tick;
    check("busy_mid", 16'(st1), 16'd2);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
`ifdef MULT_CTRL_ERR_EN
    check("busy_err", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd5, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    void'(sb1.pop_back());
    tick;
    check("err_hold", 16'({st1, err1}), 16'({3'd5, 1'b1}));
    start1 = 1'b1;
    sb1.push_back(16'h3872);
    #1;
    check("err_restart_clear", 16'({ena1, sclr1}), 16'({1'b1, 1'b0}));
    tick;
    start1 = 1'b0;
    check("err_to_lsb", 16'({st1, err1}), 16'({3'd1, 1'b0}));
    repeat (4) tick;
    check("err_recover_done", 16'({st1, done1}), 16'({3'd4, 1'b1}));
`else
    check("busy_ignored", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd2, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    tick;
    check("busy_msb", 16'({st1, err1}), 16'({3'd3, 1'b0}));
    tick;
    check("busy_done", 16'({st1, done1, err1}), 16'({3'd4, 1'b1, 1'b0}));
`endif
    tick;
    check("busy_idle", 16'(st1), 16'd0);

    // Asynchronous reset in MID with start high
    a1 = 8'hFF; b1 = 8'h01;
    start1 = 1'b1;
    sb1.push_back(16'h00FF);
    tick;
    start1 = 1'b0;
    tick;
    check("pre_reset_mid", 16'(st1), 16'd2);
    start1 = 1'b1;
    #1;
    aclr_n = 1'b0;
    #1;
    check("async_reset", pk(st1, isel1, ssel1, ena1, sclr1, done1, err1),
          pk(3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    void'(sb1.pop_back());
    start1 = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;
    tick;
    check("post_reset_idle", 16'(st1), 16'd0);

    // Product after reset abort: accumulator is cleared by the new start
    start1 = 1'b1;
    sb1.push_back(16'h00FF);
    tick;
    start1 = 1'b0;
    repeat (5) tick;
    check("recover_idle", 16'(st1), 16'd0);

    repeat (2) tick;
    check("sb1_drained", 16'(sb1.size()), 16'd0);
    check("sb3_drained", 16'(sb3.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
